aiv_sync_generator: RTL
=======================

Name: aiv_sync_generator

Overview:
- Free-running PAL 625-line interlaced timing generator for the AIV video path, clocked at 81 MHz with one dot per six clocks (13.5 MHz dot rate).
- Produces hsync/vsync pulses, sync levels and field parity: the transmit-side counterpart of the AIV active frame tracker.
- Also emits active dot/line coordinates, display enable and a frame start flag for local overlay/pixel sourcing.
- Geometry: 864 dots/line, field A (odd) 312 lines, field B (even) 313 lines.

Parameters:
H_TOTAL, 864, dots per line
H_SYNC_WIDTH, 64, dots hsync_level is high from dot 0
ACTIVE_H_START, 72, first active dot
ACTIVE_W, 720, active dots per line
ODD_LINES, 312, lines in odd field
EVEN_LINES, 313, lines in even field
V_SYNC_LINES, 3, lines vsync_level is high from field line 0
ACTIVE_V_START, 23, first active field line
ACTIVE_H_LINES, 288, active lines per field

Ports:
clk  input  1  81 MHz clock
nReset  input  1  asynchronous active-low reset
clkPhase  input  3  external phase count 0-5; dot tick when 3'b000
enable  input  1  run request
hsync  output  1  one-clk pulse at dot 0 of every line
vsync  output  1  one-clk pulse at dot 0, line 0 of every field (coincident with hsync)
hsync_level  output  1  high while dot < H_SYNC_WIDTH
vsync_level  output  1  high while field line < V_SYNC_LINES
isFieldOdd  output  1  1 = odd field, 0 = even field
active_dot  output  10  0-719 in active region, else 0
active_line  output  10  frame line 0-575 in active region, else 0
display_enable  output  1  high in active region
frame_start_flag  output  1  one-clk pulse at the first active dot of an odd field
running  output  1  high in RUN or STOPPING

Behaviour:
- Reset is asynchronous, active-low; clock is clk. Reset: state IDLE, counters 0, every output 0. Assertion mid-operation clears all outputs immediately.
- Tick = clkPhase==3'b000. Counters and all outputs change only on the clk edge of a tick; outputs are registered from next-position logic, so they describe the position the counters take on that same edge. Zero added latency.
- hsync, vsync and frame_start_flag are high for exactly one clk, the edge after the tick that sets them. Level outputs hold for whole dots.
- FSM:
  - IDLE -> RUN on a tick with enable=1. The entry tick is position dot 0, line 0, odd field: hsync, vsync, hsync_level and vsync_level all assert and isFieldOdd=1.
  - RUN -> STOPPING on a tick with enable=0.
  - STOPPING -> RUN on a tick with enable=1. No counter disturbance.
  - STOPPING -> IDLE on the tick that would wrap from even-field last line (312), dot 863. All outputs go to 0.
- Counters:
  - dot 0..H_TOTAL-1 wraps to 0.
  - At dot wrap, line increments. It wraps at ODD_LINES-1 (odd) or EVEN_LINES-1 (even).
  - At line wrap, isFieldOdd toggles.
  - Frame = 625 lines = 540000 dots = 3240000 clk.
- Active region: ACTIVE_H_START <= dot < ACTIVE_H_START+ACTIVE_W and ACTIVE_V_START <= line < ACTIVE_V_START+ACTIVE_H_LINES.
  - active_dot = dot-72.
  - active_line = (line-23)*2 + isFieldOdd, computed in 10 bits; max 575.
  - Outside the region, active_dot, active_line and display_enable are 0.
  - Even-field lines 311-312 are inactive.
- frame_start_flag: odd field, line 23, dot 72.
- Non-tick clocks hold all state except the one-clk pulse clearing.

Test Plan:
- Reset, enable=1, then first tick -> next clk: hsync=vsync=1 for 1 clk, isFieldOdd=1, running=1. Next hsync exactly 5184 clk later; hsync_level high 384 clk per line.
- Free run two fields -> 312 hsyncs odd-to-even vsync, then 313 even-to-odd. isFieldOdd toggles at each vsync. vsync period alternates 1617408/1622592 clk. vsync_level spans 3 lines.
- Odd field, line 23, dot 72 -> display_enable=1, active_dot=0, active_line=1, frame_start_flag 1 clk. Dot 791 -> active_dot=719. Dot 792 -> display_enable=0, active_dot=0.
- Even field line 23 -> active_line=0. Odd line 310 -> 575. Even line 310 -> 574. Line 311 -> display_enable=0. No frame_start_flag in the even field.
- Drop enable mid odd field -> counters continue through the even field, running falls after the even last dot, outputs 0. Re-raising enable during STOPPING keeps sync periods unbroken.
- Assert nReset mid-line -> all outputs 0 asynchronously. Release with enable=1 -> restart at dot 0, line 0, odd field, with vsync pulse.

Source files
------------

// File: rtl/aiv_sync_generator.sv
// PAL 625-line interlaced sync generator: dot/line/field counters advanced on
// clkPhase ticks, with registered sync pulses, sync levels and active-region coordinates.
module aiv_sync_generator #(
  parameter int unsigned H_TOTAL        = 864,
  parameter int unsigned H_SYNC_WIDTH   = 64,
  parameter int unsigned ACTIVE_H_START = 72,
  parameter int unsigned ACTIVE_W       = 720,
  parameter int unsigned ODD_LINES      = 312,
  parameter int unsigned EVEN_LINES     = 313,
  parameter int unsigned V_SYNC_LINES   = 3,
  parameter int unsigned ACTIVE_V_START = 23,
  parameter int unsigned ACTIVE_H_LINES = 288
) (
  input  logic       clk,
  input  logic       nReset,
  input  logic [2:0] clkPhase,
  input  logic       enable,
  output logic       hsync,
  output logic       vsync,
  output logic       hsync_level,
  output logic       vsync_level,
  output logic       isFieldOdd,
  output logic [9:0] active_dot,
  output logic [9:0] active_line,
  output logic       display_enable,
  output logic       frame_start_flag,
  output logic       running
);

  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] ODD_LAST  = 10'(ODD_LINES - 1);
  localparam logic [9:0] EVEN_LAST = 10'(EVEN_LINES - 1);
  localparam logic [9:0] HS_W      = 10'(H_SYNC_WIDTH);
  localparam logic [9:0] VS_L      = 10'(V_SYNC_LINES);
  localparam logic [9:0] AH_S      = 10'(ACTIVE_H_START);
  localparam logic [9:0] AH_E      = 10'(ACTIVE_H_START + ACTIVE_W);
  localparam logic [9:0] AV_S      = 10'(ACTIVE_V_START);
  localparam logic [9:0] AV_E      = 10'(ACTIVE_V_START + ACTIVE_H_LINES);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN      = 2'd1,
    S_STOPPING = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [9:0] dot_q, dot_d;
  logic [9:0] line_q, line_d;
  logic       odd_q, odd_d;

  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       hsync_level_q, hsync_level_d;
  logic       vsync_level_q, vsync_level_d;
  logic [9:0] active_dot_q, active_dot_d;
  logic [9:0] active_line_q, active_line_d;
  logic       display_enable_q, display_enable_d;
  logic       frame_start_q, frame_start_d;

  logic       tick;
  logic       dot_wrap;
  logic       line_wrap;
  logic [9:0] adv_dot;
  logic [9:0] adv_line;
  logic       adv_odd;
  logic       load;
  logic       clear;
  logic       in_active;
  logic [9:0] rel_line;

  // Position the counters would take if they advance on this tick.
  always_comb begin
    tick      = (clkPhase == 3'b000);
    dot_wrap  = (dot_q == H_LAST);
    line_wrap = dot_wrap && (odd_q ? (line_q == ODD_LAST) : (line_q == EVEN_LAST));
    adv_dot   = dot_wrap ? 10'd0 : dot_q + 10'd1;
    adv_line  = !dot_wrap ? line_q : (line_wrap ? 10'd0 : line_q + 10'd1);
    adv_odd   = line_wrap ? !odd_q : odd_q;
  end

  always_comb begin
    state_d = state_q;
    dot_d   = dot_q;
    line_d  = line_q;
    odd_d   = odd_q;
    load    = 1'b0;
    clear   = 1'b0;
    if (tick) begin
      case (state_q)
        S_IDLE: begin
          if (enable) begin
            state_d = S_RUN;
            dot_d   = 10'd0;
            line_d  = 10'd0;
            odd_d   = 1'b1;
            load    = 1'b1;
          end
        end
        S_RUN: begin
          if (!enable) state_d = S_STOPPING;
          dot_d  = adv_dot;
          line_d = adv_line;
          odd_d  = adv_odd;
          load   = 1'b1;
        end
        S_STOPPING: begin
          if (enable) begin
            state_d = S_RUN;
            dot_d   = adv_dot;
            line_d  = adv_line;
            odd_d   = adv_odd;
            load    = 1'b1;
          end else if (!odd_q && line_wrap) begin
            // End of the even field: the frame is complete, park in IDLE.
            state_d = S_IDLE;
            dot_d   = 10'd0;
            line_d  = 10'd0;
            odd_d   = 1'b0;
            clear   = 1'b1;
          end else begin
            dot_d  = adv_dot;
            line_d = adv_line;
            odd_d  = adv_odd;
            load   = 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          dot_d   = 10'd0;
          line_d  = 10'd0;
          odd_d   = 1'b0;
          clear   = 1'b1;
        end
      endcase
    end
  end

  // Outputs describe the position being loaded on this edge.
  always_comb begin
    rel_line  = line_d - AV_S;
    in_active = (dot_d >= AH_S) && (dot_d < AH_E) && (line_d >= AV_S) && (line_d < AV_E);

    hsync_d          = 1'b0;
    vsync_d          = 1'b0;
    frame_start_d    = 1'b0;
    hsync_level_d    = hsync_level_q;
    vsync_level_d    = vsync_level_q;
    active_dot_d     = active_dot_q;
    active_line_d    = active_line_q;
    display_enable_d = display_enable_q;

    if (load) begin
      hsync_d          = (dot_d == 10'd0);
      vsync_d          = (dot_d == 10'd0) && (line_d == 10'd0);
      hsync_level_d    = (dot_d < HS_W);
      vsync_level_d    = (line_d < VS_L);
      display_enable_d = in_active;
      active_dot_d     = in_active ? (dot_d - AH_S) : 10'd0;
      active_line_d    = in_active ? ((rel_line << 1) | {9'd0, odd_d}) : 10'd0;
      frame_start_d    = in_active && odd_d && (line_d == AV_S) && (dot_d == AH_S);
    end else if (clear) begin
      hsync_level_d    = 1'b0;
      vsync_level_d    = 1'b0;
      display_enable_d = 1'b0;
      active_dot_d     = 10'd0;
      active_line_d    = 10'd0;
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q          <= S_IDLE;
      dot_q            <= 10'd0;
      line_q           <= 10'd0;
      odd_q            <= 1'b0;
      hsync_q          <= 1'b0;
      vsync_q          <= 1'b0;
      hsync_level_q    <= 1'b0;
      vsync_level_q    <= 1'b0;
      active_dot_q     <= 10'd0;
      active_line_q    <= 10'd0;
      display_enable_q <= 1'b0;
      frame_start_q    <= 1'b0;
    end else begin
      state_q          <= state_d;
      dot_q            <= dot_d;
      line_q           <= line_d;
      odd_q            <= odd_d;
      hsync_q          <= hsync_d;
      vsync_q          <= vsync_d;
      hsync_level_q    <= hsync_level_d;
      vsync_level_q    <= vsync_level_d;
      active_dot_q     <= active_dot_d;
      active_line_q    <= active_line_d;
      display_enable_q <= display_enable_d;
      frame_start_q    <= frame_start_d;
    end
  end

  assign hsync            = hsync_q;
  assign vsync            = vsync_q;
  assign hsync_level      = hsync_level_q;
  assign vsync_level      = vsync_level_q;
  assign isFieldOdd       = odd_q;
  assign active_dot       = active_dot_q;
  assign active_line      = active_line_q;
  assign display_enable   = display_enable_q;
  assign frame_start_flag = frame_start_q;
  assign running          = (state_q != S_IDLE);

endmodule
